clock_enable_scheduler: RTL
===========================

// Module: clock_enable_scheduler
// PURPOSE
//   Synthesizable replacement for sim-only clock generation inside the matching core: all logic runs on the single
//   100 MHz system clock and this block issues per-stage clock-enable strobes instead of derived clocks.
//   It sequences a run of the datapath: programmable per-channel divide ratios, start/stop control, bounded bursts.
//   Sits between the top-level controller and the pipeline stages (image fetch, correlator, result writer).
// PARAMETERS
//   NUM_CH   4    number of clock-enable channels
//   DIV_W    8    divide-ratio width; channel period = div+1 base cycles (1..256)
//   BURST_W  16   burst-length width in base cycles; 0 = run until stop
// PORTS
//   clk        in   1                 system clock, 100 MHz
//   rst        in   1                 synchronous, active-high reset
//   cfg_we     in   1                 write divide ratio for channel cfg_ch
//   cfg_ch     in   $clog2(NUM_CH)    channel index; indices >= NUM_CH ignored
//   cfg_div    in   DIV_W             divide ratio (period-1)
//   start      in   1                 begin run (sampled in IDLE only)
//   stop       in   1                 end run (sampled in RUN only)
//   burst_len  in   BURST_W           run length, sampled with start
//   ce         out  NUM_CH            one-cycle enable strobes
//   busy       out  1                 high in RUN
//   done       out  1                 one-cycle pulse at end of run
//   cycle_cnt  out  BURST_W           base cycles elapsed in current/last run
// BEHAVIOUR
//   Reset: state=IDLE; ce=0, busy=0, done=0, cycle_cnt=0; all div regs=0, all shadow regs=0, phase counters=0.
//   States: IDLE -> RUN on start; RUN -> FINISH on stop or burst exhausted; FINISH -> IDLE unconditionally (1 cycle).
//   Outputs registered: start at edge N -> busy=1 and ce=all-ones at edge N+1 (all channels phase-aligned).
//   Channel i in RUN: phase counter loads div_i on each ce, else decrements; ce[i]=1 on the cycle counter is 0.
//     div_i=0 -> ce[i] high every RUN cycle. ce=0 in IDLE and FINISH.
//   cycle_cnt: cleared on start, +1 per RUN cycle, saturates at all-ones (no wrap); holds value after run.
//   Burst: burst_len=B>0 -> exactly B RUN cycles, then FINISH. B=0 -> RUN until stop, cycle_cnt saturates.
//   done=1 for exactly the FINISH cycle; busy=0 from FINISH onward.
//   stop: RUN cycle in which stop is sampled is the last one with ce active; stop in IDLE/FINISH ignored.
//   start in RUN/FINISH ignored (no restart, no queueing). start and stop together in IDLE: start wins.
//   cfg_we in IDLE: div reg written next cycle. In RUN: written to shadow, applied to div reg when that channel's
//     ce next fires (no truncated period). Two writes before apply: last one wins.
//   Reset asserted mid-run: immediate return to reset values, no done pulse.
// CONFIGURATION
//   SCHED_PAUSE_EN defined: adds input port pause (1 bit). pause=1 in RUN freezes phase counters, burst counter
//     and cycle_cnt, forces ce=0; stop is still honoured while paused. Resume continues phase exactly.
//   SCHED_PAUSE_EN undefined: no pause port; counters advance every RUN cycle.
// STRUCTURE
//   Package clock_sched_pkg: state enum (SCHED_IDLE, SCHED_RUN, SCHED_FINISH), default widths, base period constant.
//   Sub-module ce_divider (one per channel, generate loop): div reg, shadow reg + pending flag, phase counter, ce.
//   Top: FSM, burst counter, cycle_cnt, cfg decode.
// TESTING
//   div={0,1,3,9}, start, burst_len=20 -> ce[0] 20 pulses, ce[1] 10, ce[2] 5, ce[3] 2; done at cycle 21; cycle_cnt=20.
//   burst_len=0, start, stop after 7 RUN cycles -> exactly 7 RUN cycles, one done pulse, cycle_cnt=7.
//   div[2]=3, RUN, write div[2]=1 mid-period -> current 4-cycle period completes, then 2-cycle period.
//   start+stop same cycle in IDLE -> run starts; start during RUN -> ignored, cycle_cnt keeps counting.
//   rst asserted at RUN cycle 5 -> next cycle ce=0, busy=0, done=0, cycle_cnt=0, all div regs=0.
//   SCHED_PAUSE_EN: div=3, burst 12, pause cycles 4-6 -> run lasts 15 cycles, ce[ch] phase unbroken, cycle_cnt=12.

Source files
------------

// File: rtl/clock_sched_pkg.sv
// Shared types and default sizes for the clock-enable scheduler.
package clock_sched_pkg;

    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_DIV_W      = 8;
    localparam int unsigned DEF_BURST_W    = 16;
    // Base clock period in picoseconds (100 MHz system clock).
    localparam int unsigned BASE_PERIOD_PS = 10000;

    typedef enum logic [1:0] {
        SCHED_IDLE   = 2'd0,
        SCHED_RUN    = 2'd1,
        SCHED_FINISH = 2'd2
    } sched_state_e;

    // Channel-index width; never zero, even for a single channel.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_enable_scheduler_ce_divider.sv
// One clock-enable channel: divide-ratio register, run-time shadow
// register with pending flag, phase counter and registered strobe.
module ce_divider #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,   // entering the first RUN cycle
    input  logic             i_adv,    // entering a further counted RUN cycle
    input  logic             i_run,    // scheduler currently in RUN
    input  logic             i_we,
    input  logic [DIV_W-1:0] i_wdata,
    output logic             o_ce
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pending;
    logic [DIV_W-1:0] r_cnt;
    logic             r_ce;
    logic [DIV_W-1:0] w_next_div;
    logic             w_fire;

    // A pending shadow value takes effect at the fire that starts a new period.
    assign w_next_div = r_pending ? r_shadow : r_div;
    assign w_fire     = i_load || (i_adv && (r_cnt == '0));
    assign o_ce       = r_ce;

    // r_cnt counts the counted cycles still to go before the next strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div     <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_ce      <= 1'b0;
        end else begin
            r_ce <= w_fire;
            if (w_fire) begin
                r_cnt <= w_next_div;
                r_div <= w_next_div;
            end else if (i_adv) begin
                r_cnt <= r_cnt - DIV_W'(1);
            end
            if (i_we && i_run) begin
                r_shadow  <= i_wdata;
                r_pending <= 1'b1;
            end else if (i_we) begin
                r_div     <= i_wdata;
                r_pending <= 1'b0;
            end else if (w_fire) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Clock-enable scheduler: run FSM, burst counter, cycle counter and
// configuration decode feeding one ce_divider per channel.
// Optional feature: define SCHED_PAUSE_EN to add the pause input.
// Pause is sampled like start: a RUN cycle is frozen (ce=0, counters
// held) when pause was high at the edge that entered it. The first RUN
// cycle after start is never frozen so all channels stay phase-aligned.
module clock_enable_scheduler
    import clock_sched_pkg::*;
#(
    parameter  int unsigned NUM_CH  = DEF_NUM_CH,
    parameter  int unsigned DIV_W   = DEF_DIV_W,
    parameter  int unsigned BURST_W = DEF_BURST_W,
    localparam int unsigned CH_W    = ch_idx_w(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic               start,
    input  logic               stop,
    input  logic [BURST_W-1:0] burst_len,
    output logic [NUM_CH-1:0]  ce,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] cycle_cnt
`ifdef SCHED_PAUSE_EN
    ,
    input  logic               pause
`endif
);

    sched_state_e       r_state;
    logic               r_busy;
    logic               r_done;
    logic [BURST_W-1:0] r_cycle_cnt;
    logic [BURST_W-1:0] r_burst_left;
    logic               r_burst_mode;
    logic               r_paused;

    logic               w_pause;
    logic               w_end_run;
    logic               w_load;
    logic               w_adv;
    logic               w_in_run;
    logic [NUM_CH-1:0]  w_ce;

`ifdef SCHED_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // Run ends after the cycle that samples stop or the last counted burst cycle.
    assign w_in_run  = (r_state == SCHED_RUN);
    assign w_end_run = w_in_run &&
                       (stop || (r_burst_mode && !r_paused &&
                                 (r_burst_left == BURST_W'(1))));
    assign w_load    = (r_state == SCHED_IDLE) && start;
    assign w_adv     = w_in_run && !w_end_run && !w_pause;

    assign ce        = w_ce;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cycle_cnt = r_cycle_cnt;

    // Run sequencing with registered busy/done and cycle/burst bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SCHED_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cycle_cnt  <= '0;
            r_burst_left <= '0;
            r_burst_mode <= 1'b0;
            r_paused     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                SCHED_IDLE: begin
                    if (start) begin
                        r_state      <= SCHED_RUN;
                        r_busy       <= 1'b1;
                        r_cycle_cnt  <= '0;
                        r_burst_left <= burst_len;
                        r_burst_mode <= (burst_len != '0);
                        r_paused     <= 1'b0;
                    end
                end
                SCHED_RUN: begin
                    if (!r_paused) begin
                        if (r_cycle_cnt != '1) begin
                            r_cycle_cnt <= r_cycle_cnt + BURST_W'(1);
                        end
                        r_burst_left <= r_burst_left - BURST_W'(1);
                    end
                    if (w_end_run) begin
                        r_state  <= SCHED_FINISH;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_paused <= 1'b0;
                    end else begin
                        r_paused <= w_pause;
                    end
                end
                SCHED_FINISH: begin
                    r_state <= SCHED_IDLE;
                end
                default: begin
                    r_state <= SCHED_IDLE;
                end
            endcase
        end
    end

    // Per-channel write decode and divider instances.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_sel;
        assign w_sel = cfg_we && (cfg_ch == CH_W'(g));

        ce_divider #(
            .DIV_W (DIV_W)
        ) u_div (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_load  (w_load),
            .i_adv   (w_adv),
            .i_run   (w_in_run),
            .i_we    (w_sel),
            .i_wdata (cfg_div),
            .o_ce    (w_ce[g])
        );
    end

endmodule
